// File: rtl/decode_pkg.sv
// Decode-stage types shared with execute; mult_t selects the RV64M operation.
package decode_pkg;
    typedef enum logic [3:0] {
        MT_MUL, MT_MULH, MT_MULHSU, MT_MULHU,
        MT_DIV, MT_DIVU, MT_REM, MT_REMU,
        MT_MULW, MT_DIVW, MT_DIVUW, MT_REMW, MT_REMUW
    } mult_t;
endpackage

// File: rtl/multdiv_pkg.sv
// Mult/div unit types, defaults and small op-classification helpers.
package multdiv_pkg;
    import decode_pkg::*;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} multdiv_state_t;

    localparam int DIV_ITERS_DEF  = 64;
    localparam int MUL_CYCLES_DEF = 2;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic op_is_w(input mult_t op);
        return (op == MT_MULW) || (op == MT_DIVW) || (op == MT_DIVUW) ||
               (op == MT_REMW) || (op == MT_REMUW);
    endfunction

    function automatic logic op_is_rem(input mult_t op);
        return (op == MT_REM) || (op == MT_REMU) || (op == MT_REMW) || (op == MT_REMUW);
    endfunction

    function automatic logic op_is_div(input mult_t op);
        return (op == MT_DIV) || (op == MT_DIVU) || (op == MT_REM) || (op == MT_REMU) ||
               (op == MT_DIVW) || (op == MT_DIVUW) || (op == MT_REMW) || (op == MT_REMUW);
    endfunction

    function automatic logic op_is_signed_div(input mult_t op);
        return (op == MT_DIV) || (op == MT_REM) || (op == MT_DIVW) || (op == MT_REMW);
    endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-divide step: shift {rem,quo} left, subtract divisor when it fits.
module div_step (
    input  logic [63:0] i_rem,
    input  logic [63:0] i_quo,
    input  logic [63:0] i_dvs,
    output logic [63:0] o_rem,
    output logic [63:0] o_quo
);
    logic [64:0] w_shift;
    logic [64:0] w_diff;

    assign w_shift = {i_rem, i_quo[63]};
    assign w_diff  = w_shift - {1'b0, i_dvs};
    assign o_rem   = w_diff[64] ? w_shift[63:0] : w_diff[63:0];
    assign o_quo   = {i_quo[62:0], ~w_diff[64]};
endmodule

// File: rtl/multdiv_unit.sv
// RV64M multiply/divide execute unit: registered multiply, radix-2 restoring divide.
// Optional MULTDIV_EARLY_OUT_EN: special divides skip DIV, W divides run 32 iterations.
//   state  | meaning
//   IDLE   | ready for a new op
//   MUL    | multiply settling, MUL_CYCLES+1 edges
//   DIV    | one quotient bit per edge
//   FIX    | two edges: apply signs / special cases, then select and extend
//   DONE   | result held until out_ready
module multdiv_unit
    import decode_pkg::*;
    import multdiv_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_ITERS  = DIV_ITERS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  mult_t       mult_type,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        busy
);
    localparam int CNT_MAX = (DIV_ITERS > MUL_CYCLES) ? DIV_ITERS : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    multdiv_state_t r_state, w_next;
    mult_t          r_op;
    logic [63:0]    r_quo, r_rem, r_opb, r_dvd, r_result;
    logic [CNT_W-1:0] r_cnt, w_cnt_last;
    logic           r_neg_q, r_neg_r, r_div0, r_ovf, r_fix_ph, r_w_short;

    logic [63:0] w_a_ext, w_b_ext, w_a_abs, w_b_abs, w_prod, w_step_rem, w_step_quo, w_sel;
    logic        w_in_w, w_in_uw, w_in_div, w_in_sgn, w_a_neg, w_b_neg, w_b_zero, w_ovf;
    logic        w_accept, w_early, w_short;

    assign w_in_w   = op_is_w(mult_type);
    assign w_in_div = op_is_div(mult_type);
    assign w_in_sgn = op_is_signed_div(mult_type);
    assign w_in_uw  = (mult_type == MT_DIVUW) || (mult_type == MT_REMUW);
    assign w_a_ext  = !w_in_w ? a : (w_in_uw ? {32'b0, a[31:0]} : sext32(a[31:0]));
    assign w_b_ext  = !w_in_w ? b : (w_in_uw ? {32'b0, b[31:0]} : sext32(b[31:0]));
    assign w_a_neg  = w_in_sgn & w_a_ext[63];
    assign w_b_neg  = w_in_sgn & w_b_ext[63];
    assign w_a_abs  = w_a_neg ? 64'd0 - w_a_ext : w_a_ext;
    assign w_b_abs  = w_b_neg ? 64'd0 - w_b_ext : w_b_ext;
    assign w_b_zero = (w_b_ext == 64'd0);
    assign w_ovf    = w_in_sgn && (w_b_ext == {64{1'b1}}) &&
                      (w_a_ext == (w_in_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    assign w_accept = in_valid && (r_state == S_IDLE) && !flush;

`ifdef MULTDIV_EARLY_OUT_EN
    assign w_early = w_in_div && (w_b_zero || w_ovf);
    assign w_short = w_in_w;
`else
    assign w_early = 1'b0;
    assign w_short = 1'b0;
`endif

    assign w_cnt_last = r_w_short ? CNT_W'(31) : CNT_W'(DIV_ITERS - 1);
    assign w_prod     = r_quo * r_opb;
    assign w_sel      = op_is_rem(r_op) ? r_rem : r_quo;

    div_step u_div_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_opb),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = !w_in_div ? S_MUL : (w_early ? S_FIX : S_DIV);
            S_MUL:  if (r_cnt == CNT_W'(MUL_CYCLES)) w_next = S_DONE;
            S_DIV:  if (r_cnt == w_cnt_last) w_next = S_FIX;
            S_FIX:  if (r_fix_ph) w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    assign result = r_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op <= MT_MUL;   r_quo <= '0;    r_rem <= '0;     r_opb <= '0;
            r_dvd <= '0;      r_result <= '0; r_cnt <= '0;     r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;  r_div0 <= 1'b0; r_ovf <= 1'b0;   r_fix_ph <= 1'b0;
            r_w_short <= 1'b0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op      <= mult_type;
                    r_cnt     <= '0;
                    r_fix_ph  <= 1'b0;
                    r_rem     <= '0;
                    r_dvd     <= w_a_ext;
                    r_neg_q   <= w_a_neg ^ w_b_neg;
                    r_neg_r   <= w_a_neg;
                    r_div0    <= w_b_zero;
                    r_ovf     <= w_ovf;
                    r_w_short <= w_short;
                    // short W divides pre-shift the dividend so 32 steps consume it
                    r_quo     <= !w_in_div ? w_a_ext : (w_short ? {w_a_abs[31:0], 32'b0} : w_a_abs);
                    r_opb     <= w_in_div ? w_b_abs : w_b_ext;
                end
                S_MUL: begin
                    if (r_cnt == CNT_W'(MUL_CYCLES))
                        r_result <= (r_op == MT_MULW) ? sext32(w_prod[31:0]) : w_prod;
                    else
                        r_cnt <= r_cnt + CNT_W'(1);
                end
                S_DIV: begin
                    r_rem <= w_step_rem;
                    r_quo <= w_step_quo;
                    r_cnt <= (r_cnt == w_cnt_last) ? '0 : r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    if (!r_fix_ph) begin
                        r_fix_ph <= 1'b1;
                        if (r_div0) begin
                            r_quo <= {64{1'b1}};
                            r_rem <= r_dvd;
                        end else if (r_ovf) begin
                            r_quo <= r_dvd;
                            r_rem <= '0;
                        end else begin
                            r_quo <= r_neg_q ? 64'd0 - r_quo : r_quo;
                            r_rem <= r_neg_r ? 64'd0 - r_rem : r_rem;
                        end
                    end else begin
                        r_result <= op_is_w(r_op) ? sext32(w_sel[31:0]) : w_sel;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed plan cases plus random ops vs an arithmetic model.
module tb_multdiv_unit;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, out_ready;
    mult_t       mult_type;
    logic [63:0] a, b, result;
    logic        in_ready, out_valid, busy;
    logic [63:0] last_exp;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    multdiv_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mult_type(mult_type), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] model(input mult_t op, input logic [63:0] av, input logic [63:0] bv);
        logic signed [63:0] sa, sb;
        logic signed [31:0] sa32, sb32;
        logic [63:0] q, r;
        logic [31:0] q32, r32;
        sa = av; sb = bv; sa32 = av[31:0]; sb32 = bv[31:0];
        q = '1; r = av; q32 = '1; r32 = av[31:0];
        case (op)
            MT_MULW: begin q = av * bv; return sx(q[31:0]); end
            MT_DIV, MT_REM: begin
                if (bv == 64'd0) begin q = '1; r = av; end
                else if (av == 64'h8000_0000_0000_0000 && bv == '1) begin q = av; r = 0; end
                else begin q = sa / sb; r = sa % sb; end
                return (op == MT_DIV) ? q : r;
            end
            MT_DIVU, MT_REMU: begin
                if (bv != 64'd0) begin q = av / bv; r = av % bv; end
                return (op == MT_DIVU) ? q : r;
            end
            MT_DIVW, MT_REMW: begin
                if (sb32 == 0) begin q32 = '1; r32 = av[31:0]; end
                else if (av[31:0] == 32'h8000_0000 && sb32 == -1) begin q32 = av[31:0]; r32 = 0; end
                else begin q32 = sa32 / sb32; r32 = sa32 % sb32; end
                return (op == MT_DIVW) ? sx(q32) : sx(r32);
            end
            MT_DIVUW, MT_REMUW: begin
                if (bv[31:0] != 32'd0) begin q32 = av[31:0] / bv[31:0]; r32 = av[31:0] % bv[31:0]; end
                return (op == MT_DIVUW) ? sx(q32) : sx(r32);
            end
            default: return av * bv;
        endcase
    endfunction

    function automatic int exp_lat(input mult_t op, input logic [63:0] av, input logic [63:0] bv);
`ifdef MULTDIV_EARLY_OUT_EN
        logic w, sgn, special;
`endif
        if (op == MT_MUL || op == MT_MULW) return 3;
`ifdef MULTDIV_EARLY_OUT_EN
        w   = (op == MT_DIVW || op == MT_DIVUW || op == MT_REMW || op == MT_REMUW);
        sgn = (op == MT_DIV || op == MT_REM || op == MT_DIVW || op == MT_REMW);
        if (w) special = (bv[31:0] == 0) || (sgn && av[31:0] == 32'h8000_0000 && bv[31:0] == '1);
        else   special = (bv == 0) || (sgn && av == 64'h8000_0000_0000_0000 && bv == '1);
        if (special) return 2;
        if (w) return 34;
`endif
        return 66;
    endfunction

    task automatic run_op(input mult_t op, input logic [63:0] av, input logic [63:0] bv, input int hold);
        logic [63:0] exp;
        int lat;
        exp = model(op, av, bv);
        @(negedge clk);
        mult_type = op; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat(op, av, bv)));
        check("result", result, exp);
        last_exp = exp;
        in_valid = 1'b1;  // offered during DONE and on the handshake edge: must be ignored
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_result", result, exp);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("idle_after_ack", {62'd0, in_ready, busy}, 64'd2);
        check("valid_after_ack", {63'd0, out_valid}, 64'd0);
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return 64'($urandom_range(0, 20));
            3: return 64'd0 - 64'($urandom_range(1, 20));
            4: return 64'h8000_0000_0000_0000;
            5: return 64'h0000_0000_8000_0000;
            6: return {32'($urandom), 32'($urandom)} >> $urandom_range(0, 40);
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    mult_t ops [10] = '{MT_MUL, MT_DIV, MT_DIVU, MT_REM, MT_REMU,
                        MT_MULW, MT_DIVW, MT_DIVUW, MT_REMW, MT_REMUW};

    initial begin
        int k;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        mult_type = MT_MUL; a = '0; b = '0; last_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_result", result, 64'd0);
        reset = 1'b0;

        run_op(MT_MUL,   '1, 64'd7, 0);
        run_op(MT_DIV,   64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 0);
        run_op(MT_REM,   64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 0);
        run_op(MT_DIVU,  64'd5, 64'd0, 0);
        run_op(MT_REMU,  64'd5, 64'd0, 0);
        run_op(MT_DIV,   64'h8000_0000_0000_0000, '1, 0);
        run_op(MT_REM,   64'h8000_0000_0000_0000, '1, 0);
        run_op(MT_DIVW,  64'h0000_0000_8000_0000, '1, 0);
        run_op(MT_REMW,  64'h0000_0000_8000_0000, '1, 0);
        run_op(MT_DIVUW, 64'h1234_0000_0000_0009, 64'd0, 0);
        run_op(MT_MULW,  64'h1_0000, 64'h1_0000, 5);

        // flush a DIVU at iteration 10
        @(negedge clk);
        mult_type = MT_DIVU; a = 64'd1000; b = 64'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle", {62'd0, in_ready, busy}, 64'd2);
        check("flush_no_valid", {63'd0, out_valid}, 64'd0);
        check("flush_result_kept", result, last_exp);
        k = 0;
        while (k < 70 && !out_valid) begin @(posedge clk); #1; k++; end
        check("flush_stays_idle", {63'd0, out_valid}, 64'd0);

        // flush blocks an accept in IDLE
        @(negedge clk);
        mult_type = MT_MUL; a = 64'd3; b = 64'd3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_blocks_accept", {63'd0, busy}, 64'd0);

        run_op(MT_MUL, 64'd6, 64'd7, 0);

        // reset mid-operation
        @(negedge clk);
        mult_type = MT_DIV; a = 64'd100; b = 64'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_state", {61'd0, in_ready, out_valid, busy}, 64'd4);
        check("midrst_result", result, 64'd0);

        for (int i = 0; i < 40; i++)
            run_op(ops[$urandom_range(0, 9)], rnd64(), rnd64(), $urandom_range(0, 2));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
